// File: rtl/lowfreq_sample_capture_if.sv
// Bus bundle for lowfreq_sample_capture: tick/sample inputs from the clock
// generator side, pop port and status toward the register file.
// LOWFREQ_SAMPLE_TIMESTAMP_EN widens each entry by a 16-bit tick timestamp.
interface lowfreq_sample_capture_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
    localparam int OUT_W = DATA_W + 16;
`else
    localparam int OUT_W = DATA_W;
`endif
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              tick_100hz;
    logic              enable;
    logic              clear;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              rd_en;
    logic [OUT_W-1:0]  rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [LVL_W-1:0]  level;
    logic [7:0]        overflow_cnt;
    logic [7:0]        miss_cnt;

    modport master (
        output tick_100hz, enable, clear, sample_data, sample_valid, rd_en,
        input  rd_data, rd_valid, empty, full, level, overflow_cnt, miss_cnt
    );

    modport slave (
        input  tick_100hz, enable, clear, sample_data, sample_valid, rd_en,
        output rd_data, rd_valid, empty, full, level, overflow_cnt, miss_cnt
    );
endinterface

// File: rtl/lowfreq_sample_capture.sv
// Captures one sensor word per enabled 100 Hz tick into a small FIFO that the
// register file drains one word per read. Tracks saturating counts of dropped
// (FIFO full) and missed (no valid data on tick) samples.
// Optional: LOWFREQ_SAMPLE_TIMESTAMP_EN prefixes each entry with a 16-bit
// enabled-tick counter value.
module lowfreq_sample_capture #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic ACLK,
    input  logic ARESET,
    lowfreq_sample_capture_if.slave bus
);
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
    localparam int OUT_W = DATA_W + 16;
`else
    localparam int OUT_W = DATA_W;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [PW-1:0]    level_q;
    logic             empty_q;
    logic             full_q;
    logic             pending;
    logic [OUT_W-1:0] cap_word;
    logic [OUT_W-1:0] cap_word_nxt;
    logic [OUT_W-1:0] rd_data_q;
    logic             rd_valid_q;
    logic [7:0]       ovf_cnt_q;
    logic [7:0]       miss_cnt_q;
    logic             tick_en;
    logic             do_capture;
    logic             do_miss;
    logic             do_pop;
    logic             do_push;
    logic             do_drop;

`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
    logic [15:0] ts_cnt;
`endif

    // Stage decisions: a push may proceed into a full FIFO only when the head
    // leaves at the same edge, otherwise the newest sample is the one dropped.
    always_comb begin
        tick_en      = bus.tick_100hz & bus.enable;
        do_capture   = tick_en & bus.sample_valid;
        do_miss      = tick_en & ~bus.sample_valid;
        do_pop       = bus.rd_en & ~empty_q;
        do_push      = pending & (~full_q | do_pop);
        do_drop      = pending & full_q & ~do_pop;
        wr_ptr_nxt   = wr_ptr + PW'(do_push);
        rd_ptr_nxt   = rd_ptr + PW'(do_pop);
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
        cap_word_nxt = {ts_cnt, bus.sample_data};
`else
        cap_word_nxt = bus.sample_data;
`endif
    end

    // Capture, pointers, registered status, pop output and counters; clear
    // behaves exactly like reset.
    always_ff @(posedge ACLK) begin
        if (ARESET || bus.clear) begin
            pending    <= 1'b0;
            cap_word   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            pending <= do_capture;
            if (do_capture) begin
                cap_word <= cap_word_nxt;
            end
            if (do_miss && miss_cnt_q != 8'hFF) begin
                miss_cnt_q <= miss_cnt_q + 8'd1;
            end
            if (do_drop && ovf_cnt_q != 8'hFF) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            level_q <= wr_ptr_nxt - rd_ptr_nxt;
            empty_q <= (wr_ptr_nxt == rd_ptr_nxt);
            full_q  <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            rd_valid_q <= do_pop;
            if (do_pop) begin
                rd_data_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Entry storage; reset/clear suppress the write so no partial push lands.
    always_ff @(posedge ACLK) begin
        if (!ARESET && !bus.clear && do_push) begin
            mem[wr_ptr[AW-1:0]] <= cap_word;
        end
    end

`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
    // Enabled-tick counter; the captured word takes the pre-increment value.
    always_ff @(posedge ACLK) begin
        if (ARESET || bus.clear) begin
            ts_cnt <= '0;
        end else if (tick_en) begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end
`endif

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.level        = level_q;
    assign bus.overflow_cnt = ovf_cnt_q;
    assign bus.miss_cnt     = miss_cnt_q;
endmodule

// File: tb/tb_lowfreq_sample_capture.sv
// Self-checking bench for lowfreq_sample_capture: directed stimulus pushes
// expected FIFO entries into a scoreboard queue; a monitor thread compares
// every rd_valid pulse against the queue head.
module tb_lowfreq_sample_capture;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
    localparam int OUT_W = DATA_W + 16;
`else
    localparam int OUT_W = DATA_W;
`endif

    logic ACLK = 1'b0;
    logic ARESET;

    lowfreq_sample_capture_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    lowfreq_sample_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    always #5 ACLK = ~ACLK;

    int               n_vec = 0;
    int               n_err = 0;
    logic [OUT_W-1:0] exp_q [$];
    logic [OUT_W-1:0] last_pop = '0;
    logic [OUT_W-1:0] mon_exp;
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
    logic [15:0]      tb_ts = '0;
`endif

    function automatic logic [OUT_W-1:0] entry(input logic [DATA_W-1:0] d);
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
        return {tb_ts, d};
`else
        return d;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    // One tick cycle plus one idle cycle; optionally pops on the push edge.
    task automatic send(input logic valid, input logic [DATA_W-1:0] d,
                        input logic store, input logic pop_too);
        bus.tick_100hz   = 1'b1;
        bus.sample_valid = valid;
        bus.sample_data  = d;
        if (store) exp_q.push_back(entry(d));
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
        if (bus.enable) tb_ts++;
`endif
        @(negedge ACLK);
        bus.tick_100hz   = 1'b0;
        bus.sample_valid = 1'b0;
        bus.rd_en        = pop_too;
        @(negedge ACLK);
        bus.rd_en        = 1'b0;
    endtask

    task automatic reads(input int n);
        bus.rd_en = 1'b1;
        idle(n);
        bus.rd_en = 1'b0;
        idle(1);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(negedge ACLK);
        bus.clear = 1'b0;
        exp_q.delete();
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
        tb_ts = '0;
`endif
    endtask

    initial begin
        ARESET           = 1'b1;
        bus.tick_100hz   = 1'b0;
        bus.enable       = 1'b0;
        bus.clear        = 1'b0;
        bus.sample_data  = '0;
        bus.sample_valid = 1'b0;
        bus.rd_en        = 1'b0;

        fork
            forever begin
                @(negedge ACLK);
                if (bus.rd_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rd_unexpected: got rd_valid with rd_data 0x%0h, expected no pop", bus.rd_data);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("rd_data", 32'(bus.rd_data), 32'(mon_exp));
                        last_pop = mon_exp;
                    end
                end
            end
        join_none

        idle(3);
        ARESET = 1'b0;
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_rd_valid", 32'(bus.rd_valid), 0);
        check("rst_level", 32'(bus.level), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_overflow", 32'(bus.overflow_cnt), 0);
        check("rst_miss", 32'(bus.miss_cnt), 0);
        bus.enable = 1'b1;

        // basic capture and drain
        send(1'b1, 16'h0011, 1'b1, 1'b0);
        send(1'b1, 16'h0022, 1'b1, 1'b0);
        send(1'b1, 16'h0033, 1'b1, 1'b0);
        check("t1_level", 32'(bus.level), 3);
        reads(3);
        check("t1_empty", 32'(bus.empty), 1);
        check("t1_level0", 32'(bus.level), 0);

        // overflow: 10 ticks into 8 entries, newest two dropped
        for (int i = 0; i < 10; i++) send(1'b1, DATA_W'(16'h0100 + i), (i < 8), 1'b0);
        check("t2_level", 32'(bus.level), 8);
        check("t2_full", 32'(bus.full), 1);
        check("t2_overflow", 32'(bus.overflow_cnt), 2);

        // push and pop on the same edge while full: no drop
        send(1'b1, 16'h0200, 1'b1, 1'b1);
        check("t3_level", 32'(bus.level), 8);
        check("t3_full", 32'(bus.full), 1);
        check("t3_overflow", 32'(bus.overflow_cnt), 2);
        reads(8);
        check("t3_empty", 32'(bus.empty), 1);

        // read while empty is ignored
        reads(2);
        check("empty_rd_valid", 32'(bus.rd_valid), 0);
        check("empty_rd_hold", 32'(bus.rd_data), 32'(last_pop));

        // miss saturation, then disabled ticks change nothing
        for (int i = 0; i < 300; i++) send(1'b0, 16'hDEAD, 1'b0, 1'b0);
        check("t4_miss_sat", 32'(bus.miss_cnt), 32'hFF);
        check("t4_empty", 32'(bus.empty), 1);
        bus.enable = 1'b0;
        send(1'b1, 16'h0300, 1'b0, 1'b0);
        send(1'b0, 16'h0301, 1'b0, 1'b0);
        check("t4_dis_level", 32'(bus.level), 0);
        check("t4_dis_miss", 32'(bus.miss_cnt), 32'hFF);
        bus.enable = 1'b1;

        // clear together with a tick after partial fill
        for (int i = 0; i < 4; i++) send(1'b1, DATA_W'(16'h0400 + i), 1'b0, 1'b0);
        check("t5_level_pre", 32'(bus.level), 4);
        bus.clear        = 1'b1;
        bus.tick_100hz   = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'h0499;
        @(negedge ACLK);
        bus.clear        = 1'b0;
        bus.tick_100hz   = 1'b0;
        bus.sample_valid = 1'b0;
        exp_q.delete();
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
        tb_ts = '0;
`endif
        idle(1);
        check("t5_level", 32'(bus.level), 0);
        check("t5_empty", 32'(bus.empty), 1);
        check("t5_miss", 32'(bus.miss_cnt), 0);
        check("t5_overflow", 32'(bus.overflow_cnt), 0);
        check("t5_rd_valid", 32'(bus.rd_valid), 0);

        // clear on the push edge discards the pending capture
        bus.tick_100hz   = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'h04AA;
        @(negedge ACLK);
        bus.tick_100hz   = 1'b0;
        bus.sample_valid = 1'b0;
        do_clear();
        idle(1);
        check("t5_pending_drop", 32'(bus.level), 0);
        send(1'b1, 16'hABCD, 1'b1, 1'b0);
        reads(1);

        // reset mid-operation with a tick and a pop pending
        send(1'b1, 16'h0600, 1'b0, 1'b0);
        send(1'b1, 16'h0601, 1'b0, 1'b0);
        exp_q.delete();
        ARESET           = 1'b1;
        bus.rd_en        = 1'b1;
        bus.tick_100hz   = 1'b1;
        bus.sample_valid = 1'b1;
        @(negedge ACLK);
        ARESET           = 1'b0;
        bus.rd_en        = 1'b0;
        bus.tick_100hz   = 1'b0;
        bus.sample_valid = 1'b0;
`ifdef LOWFREQ_SAMPLE_TIMESTAMP_EN
        tb_ts = '0;
`endif
        idle(1);
        check("rst2_level", 32'(bus.level), 0);
        check("rst2_empty", 32'(bus.empty), 1);
        check("rst2_rd_valid", 32'(bus.rd_valid), 0);
        check("rst2_rd_data", 32'(bus.rd_data), 0);

        // miss then two valid ticks (timestamps 1 and 2 when enabled)
        do_clear();
        send(1'b0, 16'h0000, 1'b0, 1'b0);
        send(1'b1, 16'h5A5A, 1'b1, 1'b0);
        send(1'b1, 16'hA5A5, 1'b1, 1'b0);
        check("t6_miss", 32'(bus.miss_cnt), 1);
        check("t6_level", 32'(bus.level), 2);
        reads(2);

        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
